spi_reg_peripheral: RTL and testbench

//  SPI target (mode 0, MSB first) that receives 16-bit frames on the dedicated inputs and

---
 rtl/spi_reg_peripheral.sv | 170 +++++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: SPI mode-0 target that writes five 8-bit PWM control registers from 16-bit frames.
// Latency: register outputs and wr_strobe update SYNC_STAGES+2 clk after the raw ncs rising edge.
// Backpressure: none; the SPI master free-runs, so SCLK must stay at or below clk/8.
// Optional feature: `define SPI_READBACK_EN to support read frames (R/W = 0) driving cipo.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       wr_strobe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state;
  // Stage SYNC_STAGES-1 is the synchronized value; stage SYNC_STAGES is its one-clk-old copy.
  logic [SYNC_STAGES:0]   sclk_sync;
  logic [SYNC_STAGES:0]   ncs_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  // Marks which sync stages already hold post-reset samples.
  logic [SYNC_STAGES:0]   fill;
  // Set once ncs has been seen high after reset; a frame needs a fresh falling edge.
  logic                   armed;
  logic [4:0]             bit_cnt;
  logic [15:0]            shift_reg;

  logic       sclk_rise;
  logic       ncs_fall;
  logic       ncs_rise;
  logic       copi_s;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_wr;
  logic       frame_ok;

  assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
  assign ncs_fall   = ~ncs_sync[SYNC_STAGES-1] & ncs_sync[SYNC_STAGES];
  assign ncs_rise   = ncs_sync[SYNC_STAGES-1] & ~ncs_sync[SYNC_STAGES];
  assign copi_s     = copi_sync[SYNC_STAGES-1];

  assign frame_wr   = shift_reg[15];
  assign frame_addr = shift_reg[14:8];
  assign frame_data = shift_reg[7:0];
  assign frame_ok   = (bit_cnt == 5'd16) && frame_wr && (int'(frame_addr) <= MAX_ADDR);

  // Input synchronizers, edge-history flop and post-reset arming of ncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-1:0], ncs};
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      if ((&fill) && ncs_sync[SYNC_STAGES]) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame FSM: collect bits while ncs is low, commit a valid write when ncs rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall && armed) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != 5'd17) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (frame_ok) begin
            wr_strobe <= 1'b1;
            case (frame_addr)
              7'd0:    en_reg_out_7_0  <= frame_data;
              7'd1:    en_reg_out_15_8 <= frame_data;
              7'd2:    en_reg_pwm_7_0  <= frame_data;
              7'd3:    en_reg_pwm_15_8 <= frame_data;
              7'd4:    pwm_duty_cycle  <= frame_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] hdr;
  logic [7:0] rd_data;
  logic [7:0] cipo_shift;

  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
  // Header as it will look once the 8th bit lands: {R/W, addr[6:0]}.
  assign hdr       = {shift_reg[6:0], copi_s};

  // Register file read mux; unmapped or out-of-range addresses read as zero.
  always_comb begin
    rd_data = 8'h00;
    if (int'(hdr[6:0]) <= MAX_ADDR) begin
      case (hdr[6:0])
        7'd0:    rd_data = en_reg_out_7_0;
        7'd1:    rd_data = en_reg_out_15_8;
        7'd2:    rd_data = en_reg_pwm_7_0;
        7'd3:    rd_data = en_reg_pwm_15_8;
        7'd4:    rd_data = pwm_duty_cycle;
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Load read data on the 8th sclk rise; shift only on falls after the 9th rise so bit7
  // stays valid for the master's first data sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cipo_shift <= '0;
    end else if (state != SHIFT) begin
      cipo_shift <= '0;
    end else if (sclk_rise && !ncs_rise && bit_cnt == 5'd7 && !hdr[7]) begin
      cipo_shift <= rd_data;
    end else if (sclk_fall && bit_cnt > 5'd8) begin
      cipo_shift <= {cipo_shift[6:0], 1'b0};
    end
  end

  assign cipo = cipo_shift[7];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: drives SPI frames into spi_reg_peripheral and checks register outputs.
// Writes are queued when a frame is driven and popped when wr_strobe is observed.
// Build with SPI_READBACK_EN defined to expect read data on cipo.
`timescale 1ns/1ps
module tb_spi_reg_peripheral;

  localparam int HALF = 8;   // clk cycles per SCLK half-period (SCLK = clk/16)
  localparam int NV   = 11;

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic cipo, wr_strobe;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  always #5 clk = ~clk;

  spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .cipo            (cipo),
    .wr_strobe       (wr_strobe),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  logic [4:0][7:0] act;
  assign act = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } sb_t;

  typedef struct packed {
    logic [15:0]     word;
    logic [4:0]      nbits;
    logic [1:0]      nstrobe;
    logic [4:0][7:0] exp;     // {addr4, addr3, addr2, addr1, addr0}
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[NV];
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Advance n clocks, sampling 1ns after each edge; every wr_strobe is matched to the queue.
  task automatic clk_wait(input int n);
    sb_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (wr_strobe === 1'b1) begin
        strobe_cnt++;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected: wr_strobe 1, required 0 (no write pending)");
        end else begin
          e = sb_q.pop_front();
          if (act[e.addr] !== e.data) begin
            fails++;
            $display("FAIL sb_reg%0d: got %h, required %h", e.addr, act[e.addr], e.data);
          end
        end
      end
    end
  endtask

  // Pull ncs low and clock nbits bits; cipo is captured just before rises for bits 8..15.
  task automatic spi_shift(input logic [15:0] word, input int nbits, output logic [7:0] rd);
    rd  = 8'h00;
    ncs = 1'b0;
    clk_wait(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) copi = word[15-i];
      else        copi = 1'b0;
      clk_wait(HALF);
      if (i >= 8 && i < 16) rd[15-i] = cipo;
      sclk = 1'b1;
      clk_wait(HALF);
      sclk = 1'b0;
    end
    clk_wait(HALF);
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [7:0] rd);
    spi_shift(word, nbits, rd);
    ncs = 1'b1;
    clk_wait(12);
  endtask

  task automatic push_wr(input logic [2:0] addr, input logic [7:0] data);
    sb_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  logic [7:0] rd;
  logic [7:0] rd_exp;
  int s0;
  int lat;

  initial begin
    vecs[0]  = '{16'h8455, 5'd16, 2'd1, {8'h55, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1]  = '{16'h80F0, 5'd16, 2'd1, {8'h55, 8'h00, 8'h00, 8'h00, 8'hF0}};
    vecs[2]  = '{16'h83A5, 5'd16, 2'd1, {8'h55, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[3]  = '{16'h8799, 5'd16, 2'd0, {8'h55, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[4]  = '{16'h8412, 5'd15, 2'd0, {8'h55, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[5]  = '{16'h8412, 5'd17, 2'd0, {8'h55, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[6]  = '{16'h8412, 5'd16, 2'd1, {8'h12, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[7]  = '{16'h0200, 5'd16, 2'd0, {8'h12, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[8]  = '{16'h8501, 5'd16, 2'd0, {8'h12, 8'hA5, 8'h00, 8'h00, 8'hF0}};
    vecs[9]  = '{16'h8109, 5'd16, 2'd1, {8'h12, 8'hA5, 8'h00, 8'h09, 8'hF0}};
    vecs[10] = '{16'h0412, 5'd16, 2'd0, {8'h12, 8'hA5, 8'h00, 8'h09, 8'hF0}};

    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    clk_wait(3);
    check("reset_regs", act, 40'h0);
    check("reset_strobe", wr_strobe, 1'b0);
    check("reset_cipo", cipo, 1'b0);
    rst = 1'b0;
    clk_wait(10);

    // Table of single frames applied back to back; state carries across entries.
    for (int v = 0; v < NV; v++) begin
      s0 = strobe_cnt;
      if (vecs[v].nstrobe != 2'd0) push_wr(vecs[v].word[10:8], vecs[v].word[7:0]);
      spi_frame(vecs[v].word, int'(vecs[v].nbits), rd);
      check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].nstrobe);
      for (int k = 0; k < 5; k++) begin
        check($sformatf("v%0d_reg%0d", v, k), act[k], vecs[v].exp[k]);
      end
    end
    check("sb_empty_after_table", sb_q.size(), 0);

    // Commit latency measured from the raw ncs rising edge.
    push_wr(3'd0, 8'h66);
    spi_shift(16'h8066, 16, rd);
    s0  = strobe_cnt;
    lat = 0;
    ncs = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      clk_wait(1);
      if (lat == 0 && strobe_cnt != s0) lat = k;
    end
    check("commit_latency", lat, 4);
    check("latency_strobes", strobe_cnt - s0, 1);
    check("latency_reg0", en_reg_out_7_0, 8'h66);

    // Reset in the middle of a frame, then a frame already in progress at reset exit.
    push_wr(3'd2, 8'hFF);
    spi_frame(16'h82FF, 16, rd);
    check("pre_rst_reg2", en_reg_pwm_7_0, 8'hFF);
    spi_shift(16'h8200, 10, rd);
    rst = 1'b1;
    s0  = strobe_cnt;
    clk_wait(2);
    check("midframe_rst_regs", act, 40'h0);
    check("midframe_rst_cipo", cipo, 1'b0);
    rst = 1'b0;
    clk_wait(2);
    spi_shift(16'h8277, 16, rd);
    ncs = 1'b1;
    clk_wait(12);
    check("stale_frame_strobes", strobe_cnt - s0, 0);
    check("stale_frame_regs", act, 40'h0);
    s0 = strobe_cnt;
    push_wr(3'd2, 8'h77);
    spi_frame(16'h8277, 16, rd);
    check("rearm_strobes", strobe_cnt - s0, 1);
    check("rearm_reg2", en_reg_pwm_7_0, 8'h77);

    // Readback of a written register and of an out-of-range address.
    push_wr(3'd1, 8'h33);
    spi_frame(16'h8133, 16, rd);
    check("rb_write_reg1", en_reg_out_15_8, 8'h33);
    s0 = strobe_cnt;
`ifdef SPI_READBACK_EN
    rd_exp = 8'h33;
`else
    rd_exp = 8'h00;
`endif
    spi_frame(16'h0100, 16, rd);
    check("read_addr1_cipo", rd, rd_exp);
    check("read_idle_cipo", cipo, 1'b0);
    spi_frame(16'h0600, 16, rd);
    check("read_addr6_cipo", rd, 8'h00);
    check("read_strobes", strobe_cnt - s0, 0);
    check("read_regs_kept", act, {8'h00, 8'h00, 8'h77, 8'h33, 8'h00});
    check("sb_empty_final", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
